// File: rtl/dram_defs.sv
// rtl/dram_defs.sv - shared DRAM types, address field positions and row classification helper
package dram_defs;

  // Page policy handed to dram_cmd for the request currently held
  typedef enum logic [1:0] {
    POL_NULL  = 2'd0,
    POL_EMPTY = 2'd1,
    POL_HIT   = 2'd2,
    POL_MISS  = 2'd3
  } dram_policy_t;

  // Request opcode; OP_RSVD is passed through and handled downstream as a read
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_RSVD   = 2'd3
  } dram_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_BUSY   = 2'd2
  } row_tracker_state_t;

  localparam int ADDR_W   = 33;
  localparam int OP_W     = 2;
  localparam int BG_W     = 2;
  localparam int BA_W     = 2;
  localparam int BANK_W   = BG_W + BA_W;
  localparam int ROW_BITS = 15;
  localparam int COL_W    = 10;

  // Byte-address field positions
  localparam int COL_LO_LSB = 4;
  localparam int COL_LO_W   = 2;
  localparam int BG_LSB     = 6;
  localparam int BA_LSB     = 8;
  localparam int COL_HI_LSB = 10;
  localparam int COL_HI_W   = 8;
  localparam int ROW_LSB    = 18;

  // Closed bank -> EMPTY, same row open -> HIT, other row open -> MISS
  function automatic dram_policy_t classify_row(input logic                valid,
                                                input logic [ROW_BITS-1:0] tag,
                                                input logic [ROW_BITS-1:0] row);
    if (!valid) begin
      return POL_EMPTY;
    end else if (tag == row) begin
      return POL_HIT;
    end
    return POL_MISS;
  endfunction

endpackage

// File: rtl/dram_row_tracker_if.sv
// rtl/dram_row_tracker_if.sv - request, refresh and dram_cmd hand-off bundle of the row tracker
interface dram_row_tracker_if;
  import dram_defs::*;

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [OP_W-1:0]     req_op;
  logic                refresh_all;
  logic                cmd_done;
  dram_policy_t        POLICY;
  logic [BG_W-1:0]     cmd_bg;
  logic [BA_W-1:0]     cmd_ba;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_W-1:0]    cmd_col;
  logic [OP_W-1:0]     cmd_op;

  // Requester / dram_cmd side
  modport master (
    output req_valid, req_addr, req_op, refresh_all, cmd_done,
    input  req_ready, POLICY, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_op
  );

  // Row tracker side
  modport slave (
    input  req_valid, req_addr, req_op, refresh_all, cmd_done,
    output req_ready, POLICY, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_op
  );

endinterface

// File: rtl/bank_row_table.sv
// rtl/bank_row_table.sv - per-bank open-row table; CLOSED_PAGE_EN makes every write close the bank
module bank_row_table #(
  parameter int NUM_BANKS = 16,
  parameter int ROW_W     = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_idx,
  output logic [ROW_W-1:0]             rd_tag,
  output logic                         rd_valid,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_idx,
  input  logic [ROW_W-1:0]             wr_tag,
  input  logic                         clr_all
);

  logic [NUM_BANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]     tag_q [NUM_BANKS];
  logic [ROW_W-1:0]     tag_d [NUM_BANKS];

  // Reads see the table as it was before this edge, so a same-edge refresh
  // cannot change a classification being made
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // Next-state: row write on completion, then refresh overrides it
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_en) begin
      tag_d[wr_idx] = wr_tag;
`ifdef CLOSED_PAGE_EN
      valid_d[wr_idx] = 1'b0;
`else
      valid_d[wr_idx] = 1'b1;
`endif
    end
    if (clr_all) begin
      valid_d = '0;
    end
  end

  // Table storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/dram_row_tracker.sv
// rtl/dram_row_tracker.sv - decodes one request, classifies it against the open-row table and holds it for dram_cmd (CLOSED_PAGE_EN selects closed-page)
module dram_row_tracker
  import dram_defs::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int ROW_W     = ROW_BITS
) (
  input  logic               clk,
  input  logic               rst,
  dram_row_tracker_if.slave  bus
);

  row_tracker_state_t  state_q, state_d;
  dram_policy_t        policy_q, policy_d;
  logic                ready_q, ready_d;
  logic [BG_W-1:0]     bg_q, bg_d;
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [OP_W-1:0]     op_q, op_d;

  logic [BANK_W-1:0]   bank_idx;
  logic [ROW_W-1:0]    tbl_tag;
  logic                tbl_valid;
  logic                tbl_wr_en;
  logic                unused_addr;

  // Byte-offset bits never reach the command path
  assign unused_addr = ^bus.req_addr[COL_LO_LSB-1:0];

  assign bank_idx = {bg_q, ba_q};

  bank_row_table #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_W     (ROW_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bank_idx),
    .rd_tag   (tbl_tag),
    .rd_valid (tbl_valid),
    .wr_en    (tbl_wr_en),
    .wr_idx   (bank_idx),
    .wr_tag   (row_q),
    .clr_all  (bus.refresh_all)
  );

  // FSM next-state: capture in IDLE, classify in LOOKUP, hold until cmd_done in BUSY
  always_comb begin
    state_d   = state_q;
    policy_d  = policy_q;
    ready_d   = ready_q;
    bg_d      = bg_q;
    ba_d      = ba_q;
    row_d     = row_q;
    col_d     = col_q;
    op_d      = op_q;
    tbl_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        // ready_q gates acceptance so nothing is taken in the first cycle out of reset
        if (bus.req_valid && ready_q) begin
          bg_d    = bus.req_addr[BG_LSB +: BG_W];
          ba_d    = bus.req_addr[BA_LSB +: BA_W];
          row_d   = bus.req_addr[ROW_LSB +: ROW_BITS];
          col_d   = {bus.req_addr[COL_HI_LSB +: COL_HI_W], bus.req_addr[COL_LO_LSB +: COL_LO_W]};
          op_d    = bus.req_op;
          ready_d = 1'b0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        policy_d = classify_row(tbl_valid, tbl_tag, row_q);
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.cmd_done) begin
          tbl_wr_en = 1'b1;
          policy_d  = POL_NULL;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        policy_d = POL_NULL;
        ready_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      policy_q <= POL_NULL;
      ready_q  <= 1'b0;
      bg_q     <= '0;
      ba_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      policy_q <= policy_d;
      ready_q  <= ready_d;
      bg_q     <= bg_d;
      ba_q     <= ba_d;
      row_q    <= row_d;
      col_q    <= col_d;
      op_q     <= op_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.POLICY    = policy_q;
  assign bus.cmd_bg    = bg_q;
  assign bus.cmd_ba    = ba_q;
  assign bus.cmd_row   = row_q;
  assign bus.cmd_col   = col_q;
  assign bus.cmd_op    = op_q;

endmodule
